// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the memory-arbiter state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE     = 3'b000;
  localparam logic [2:0] HSIZE_HALFWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD     = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ADDR     = 2'd1,
    ST_DATA     = 2'd2,
    ST_RESP_ERR = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: with both eligible, the one not
// granted last time wins; otherwise the sole eligible requester wins.
module rr_arb2 (
  input  logic [1:0] i_eligible,
  input  logic       i_last_grant,
  output logic       o_gnt_valid_c,
  output logic       o_gnt_idx_c
);

  always_comb begin
    o_gnt_valid_c = |i_eligible;
    o_gnt_idx_c   = 1'b0;
    if (&i_eligible) begin
      o_gnt_idx_c = ~i_last_grant;
    end else if (i_eligible[1]) begin
      o_gnt_idx_c = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Two-requester AHB-lite master sharing one data-memory slave; issues one
// non-pipelined single WORD transfer at a time with round-robin arbitration.
module ahb_mem_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       i_hclk,
  input  logic                       i_hreset,
  input  logic [1:0]                 i_req,
  input  logic [1:0]                 i_we,
  input  logic [1:0][ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0][DATA_WIDTH-1:0] i_wdata,
  output logic [1:0]                 o_done,
  output logic [1:0]                 o_err,
  output logic [DATA_WIDTH-1:0]      o_rdata,
  output logic                       o_busy,
  output logic                       o_hsel,
  output logic [1:0]                 o_htrans,
  output logic [ADDR_WIDTH-1:0]      o_haddr,
  output logic                       o_hwrite,
  output logic [2:0]                 o_hsize,
  output logic [DATA_WIDTH-1:0]      o_hwdata,
  input  logic                       i_hreadyout,
  input  logic                       i_hresp,
  input  logic [DATA_WIDTH-1:0]      i_hrdata
);

  arb_state_t r_state;
  logic       r_last_grant;
  logic [1:0] w_eligible;
  logic       w_gnt_valid;
  logic       w_gnt_idx;

  // A requester being acknowledged this cycle must not start a second transfer.
  assign w_eligible = i_req & ~o_done;

  rr_arb2 u_rr_arb2 (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_gnt_valid_c(w_gnt_valid),
    .o_gnt_idx_c  (w_gnt_idx)
  );

  // o_haddr/o_hwrite/o_hwdata double as the latched request payload.
  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      o_hsel       <= 1'b0;
      o_htrans     <= HTRANS_IDLE;
      o_haddr      <= '0;
      o_hwrite     <= 1'b0;
      o_hsize      <= HSIZE_WORD;
      o_hwdata     <= '0;
      o_done       <= '0;
      o_err        <= '0;
      o_rdata      <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_done <= '0;
      o_err  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_last_grant <= w_gnt_idx;
            o_busy       <= 1'b1;
            if (i_addr[w_gnt_idx][1:0] != 2'b00) begin
              r_state <= ST_RESP_ERR;
            end else begin
              r_state  <= ST_ADDR;
              o_hsel   <= 1'b1;
              o_htrans <= HTRANS_NONSEQ;
              o_hsize  <= HSIZE_WORD;
              o_haddr  <= i_addr[w_gnt_idx];
              o_hwrite <= i_we[w_gnt_idx];
              o_hwdata <= i_wdata[w_gnt_idx];
            end
          end
        end
        ST_ADDR: begin
          o_hsel   <= 1'b0;
          o_htrans <= HTRANS_IDLE;
          r_state  <= ST_DATA;
        end
        ST_DATA: begin
          if (i_hreadyout) begin
            o_done[r_last_grant] <= 1'b1;
            o_err[r_last_grant]  <= i_hresp;
            if (!o_hwrite) begin
              o_rdata <= i_hrdata;
            end
            o_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RESP_ERR: begin
          o_done[r_last_grant] <= 1'b1;
          o_err[r_last_grant]  <= 1'b1;
          o_busy               <= 1'b0;
          r_state              <= ST_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter with a behavioural AHB-lite memory slave.
module tb_ahb_mem_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       done;
  logic [1:0]       err;
  logic [31:0]      rdata;
  logic             busy;
  logic             hsel;
  logic [1:0]       htrans;
  logic [31:0]      haddr;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [31:0]      hwdata;
  logic             hready;
  logic             hresp;
  logic [31:0]      hrdata;

  int total = 0;
  int bad   = 0;

  int          wait_cfg = 0;
  logic        resp_cfg = 1'b0;
  logic [31:0] mem [int unsigned];

  logic        s_aph = 1'b0;
  logic        s_dph = 1'b0;
  int          s_cnt = 0;
  logic [31:0] s_addr;
  logic        s_write;

  ahb_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_hclk     (clk),
    .i_hreset   (rst_n),
    .i_req      (req),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_done     (done),
    .o_err      (err),
    .o_rdata    (rdata),
    .o_busy     (busy),
    .o_hsel     (hsel),
    .o_htrans   (htrans),
    .o_haddr    (haddr),
    .o_hwrite   (hwrite),
    .o_hsize    (hsize),
    .o_hwdata   (hwdata),
    .i_hreadyout(hready),
    .i_hresp    (hresp),
    .i_hrdata   (hrdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 32'h0;
  endfunction

  // Memory slave: address phase seen after one edge, data phase with wait_cfg stalls.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      s_aph  = 1'b0;
      s_dph  = 1'b0;
      hready = 1'b1;
      hresp  = 1'b0;
    end else begin
      if (s_dph) begin
        if (hready) begin
          if (s_write) mem[int'(s_addr)] = hwdata;
          s_dph = 1'b0;
          hresp = 1'b0;
        end else begin
          s_cnt = s_cnt - 1;
          if (s_cnt == 0) begin
            hready = 1'b1;
            hresp  = resp_cfg;
            hrdata = s_write ? 32'h0 : mem_rd(s_addr);
          end
        end
      end
      if (s_aph) begin
        s_aph = 1'b0;
        s_dph = 1'b1;
        s_cnt = wait_cfg;
        if (s_cnt == 0) begin
          hready = 1'b1;
          hresp  = resp_cfg;
          hrdata = s_write ? 32'h0 : mem_rd(s_addr);
        end else begin
          hready = 1'b0;
          hresp  = 1'b0;
        end
      end
      if (hsel && htrans == 2'b10) begin
        s_aph   = 1'b1;
        s_addr  = haddr;
        s_write = hwrite;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsel"},   32'(hsel),   32'h0);
    chk({tag, "_htrans"}, 32'(htrans), 32'h0);
    chk({tag, "_haddr"},  haddr,       32'h0);
    chk({tag, "_hwrite"}, 32'(hwrite), 32'h0);
    chk({tag, "_hsize"},  32'(hsize),  32'h2);
    chk({tag, "_hwdata"}, hwdata,      32'h0);
    chk({tag, "_done"},   32'(done),   32'h0);
    chk({tag, "_err"},    32'(err),    32'h0);
    chk({tag, "_rdata"},  rdata,       32'h0);
    chk({tag, "_busy"},   32'(busy),   32'h0);
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    req    = '0;
    we     = '0;
    addr   = '0;
    wdata  = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    mem[32'h2000] = 32'h2000_AAAA;
    mem[32'h3000] = 32'h3333_3333;

    edges(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Both request on the same edge after reset: 0,1,0,1
    req      = 2'b11;
    we       = 2'b00;
    addr[0]  = 32'h2000;
    addr[1]  = 32'h3000;
    for (int k = 0; k < 4; k++) begin
      edges(1);
      chk($sformatf("rr%0d_haddr", k), haddr, (k % 2 == 0) ? 32'h2000 : 32'h3000);
      chk($sformatf("rr%0d_hsel", k), 32'(hsel), 32'h1);
      edges(2);
      chk($sformatf("rr%0d_done", k), 32'(done), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("rr%0d_rdata", k), rdata, (k % 2 == 0) ? 32'h2000_AAAA : 32'h3333_3333);
    end
    req = 2'b00;
    edges(1);
    chk("rr_idle_busy", 32'(busy), 32'h0);

    // Zero-wait write then read of 0x1000 by requester 0
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1000; wdata[0] = 32'hDEAD_BEEF;
    edges(1);
    chk("wr_hsel",   32'(hsel),   32'h1);
    chk("wr_htrans", 32'(htrans), 32'h2);
    chk("wr_haddr",  haddr,       32'h1000);
    chk("wr_hwrite", 32'(hwrite), 32'h1);
    chk("wr_hwdata", hwdata,      32'hDEAD_BEEF);
    chk("wr_busy",   32'(busy),   32'h1);
    edges(1);
    chk("wr_dph_hsel",   32'(hsel),   32'h0);
    chk("wr_dph_htrans", 32'(htrans), 32'h0);
    chk("wr_dph_done",   32'(done),   32'h0);
    edges(1);
    chk("wr_done", 32'(done), 32'h1);
    chk("wr_err",  32'(err),  32'h0);
    req[0] = 1'b0;
    edges(1);
    req[0] = 1'b1; we[0] = 1'b0;
    edges(2);
    chk("rd_early_done", 32'(done), 32'h0);
    edges(1);
    chk("rd_done",  32'(done), 32'h1);
    chk("rd_err",   32'(err),  32'h0);
    chk("rd_rdata", rdata,     32'hDEAD_BEEF);
    req[0] = 1'b0;
    edges(1);

    // Two wait states, requester 1 read
    wait_cfg = 2;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h3000; wdata[1] = 32'hA5A5_0001;
    edges(1);
    chk("ws_hsel", 32'(hsel), 32'h1);
    for (int k = 0; k < 3; k++) begin
      edges(1);
      chk($sformatf("ws%0d_done", k),   32'(done), 32'h0);
      chk($sformatf("ws%0d_busy", k),   32'(busy), 32'h1);
      chk($sformatf("ws%0d_haddr", k),  haddr,     32'h3000);
      chk($sformatf("ws%0d_hwdata", k), hwdata,    32'hA5A5_0001);
    end
    edges(1);
    chk("ws_done",  32'(done), 32'h2);
    chk("ws_rdata", rdata,     32'h3333_3333);
    req[1] = 1'b0;
    wait_cfg = 0;
    edges(1);

    // Misaligned request: no bus activity, error two cycles after request
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1002;
    edges(1);
    chk("mis_hsel0", 32'(hsel), 32'h0);
    chk("mis_busy",  32'(busy), 32'h1);
    edges(1);
    chk("mis_hsel1", 32'(hsel), 32'h0);
    chk("mis_done",  32'(done), 32'h1);
    chk("mis_err",   32'(err),  32'h1);
    req[0] = 1'b0;
    edges(1);

    // Slave ERROR response on requester 1 write
    resp_cfg = 1'b1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h4000; wdata[1] = 32'h0BAD_0BAD;
    edges(3);
    chk("resp_done",  32'(done), 32'h2);
    chk("resp_err",   32'(err),  32'h2);
    chk("resp_rdata", rdata,     32'h3333_3333);
    req[1] = 1'b0;
    edges(1);
    resp_cfg = 1'b0;

    // Reset in the middle of the data phase
    wait_cfg = 2;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h1000;
    edges(2);
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    wait_cfg = 0;
    edges(2);
    chk("mid_rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    edges(1);
    chk("post_hsel",  32'(hsel), 32'h1);
    chk("post_haddr", haddr,     32'h1000);
    edges(2);
    chk("post_done",  32'(done), 32'h1);
    chk("post_rdata", rdata,     32'hDEAD_BEEF);
    req[0] = 1'b0;
    edges(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_mem_arbiter.md
# ahb_mem_arbiter

Two-requester AHB-lite master that shares the data-memory AHB slave between the MIPS core's load/store port (requester 0) and a secondary requester such as a DMA or boot loader (requester 1). It accepts simple word-sized request/done handshakes, arbitrates round-robin, and sequences one non-pipelined AHB-lite single transfer at a time: an address phase, then a data phase that absorbs slave wait states. It returns read data and per-requester completion and error strobes.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width
- i_hclk  in  1  bus clock; all timing on rising edge
- i_hreset  in  1  asynchronous, active-low reset
- i_req  in  [1:0]  per-requester transfer request, level, held until o_done
- i_we  in  [1:0]  per-requester direction, 1 = write
- i_addr  in  [1:0][ADDR_WIDTH-1:0]  per-requester byte address, word aligned
- i_wdata  in  [1:0][DATA_WIDTH-1:0]  per-requester write data
- o_done  out  [1:0]  one-cycle completion strobe for the granted requester
- o_err  out  [1:0]  one-cycle error strobe, coincident with o_done
- o_rdata  out  DATA_WIDTH  read data, valid while o_done is high, held until the next read completes
- o_busy  out  1  transfer in progress (state != IDLE)
- o_hsel, o_htrans[1:0], o_haddr, o_hwrite, o_hsize[2:0], o_hwdata  out  AHB-lite master address/control/write-data signals
- i_hreadyout  in  1  slave HREADYOUT; also fed back to the slave's HREADY input at top level
- i_hresp  in  1  slave response, 1 = ERROR
- i_hrdata  in  DATA_WIDTH  slave read data

## Operation
- Reset values: o_hsel=0, o_htrans=IDLE(2'b00), o_haddr=0, o_hwrite=0, o_hsize=WORD(3'b010), o_hwdata=0, o_done=0, o_err=0, o_rdata=0, o_busy=0, state=IDLE, last_grant=1 (so requester 0 wins first).
- FSM states are IDLE, ADDR, DATA, RESP_ERR.
- IDLE: eligible = i_req & ~o_done. A requester whose o_done is high in this cycle is ignored, which prevents a duplicate transfer. If both requesters are eligible, grant the one != last_grant; otherwise grant the sole requester. On grant, latch we/addr/wdata and set last_grant.
  - If the latched addr[1:0] != 0, go to RESP_ERR. No bus transfer occurs.
  - Otherwise go to ADDR.
- ADDR: o_hsel=1, o_htrans=NONSEQ(2'b10), o_hsize=WORD, o_haddr/o_hwrite from the latch, o_hwdata = latched wdata. Unconditionally go to DATA.
- DATA: o_hsel=0, o_htrans=IDLE. o_hwdata stays stable from ADDR through the end of DATA. Stay in DATA while i_hreadyout=0. When i_hreadyout=1:
  - Register o_done[g]=1.
  - Register o_err[g]=i_hresp.
  - For a read, register o_rdata=i_hrdata.
  - Return to IDLE.
- RESP_ERR: pulse o_done[g]=1 and o_err[g]=1, then return to IDLE.
- Once latched, the request payload is never re-sampled. Dropping i_req mid-transfer does not abort it, and done is still pulsed.
- Only single WORD transfers are issued. BUSY and SEQ are never driven.

## Timing
- Request seen high at edge E0 in IDLE → address phase in cycle E0–E1 → slave samples at E1 → data phase. With zero wait states, o_done is high in cycle E2–E3, which is 3 cycles after the request.
- Each slave wait state adds one cycle.
- There is no pipelining. The next address phase starts no earlier than E3→E4, giving 1 transfer per 3 cycles at best.
- A misaligned request produces o_done+o_err 2 cycles after the request.
- Asserting reset mid-transfer forces all outputs to their reset values immediately. The in-flight transfer is dropped and no o_done is issued.

## Structure
- Shared package ahb_pkg holds: HTRANS constants IDLE/BUSY/NONSEQ/SEQ, HSIZE constants BYTE/HALFWORD/WORD, and the arbiter state enum typedef.
- Sub-module rr_arb2 contains the combinational 2-way round-robin grant logic, with inputs eligible[1:0] and last_grant and outputs gnt_valid and gnt_idx. The FSM, latches and AHB drive logic live in ahb_mem_arbiter.

## Test plan
- Zero-wait slave. Req0 writes 0xDEADBEEF to 0x1000, then reads 0x1000 → o_done[0] after 3 cycles each, read returns o_rdata=0xDEADBEEF, o_err=0.
- Both requesters assert on the same edge right after reset → req0 is served first and req1 second. Keeping both asserted produces grants alternating 0,1,0,1.
- Slave with 2 wait states, req1 reads → DATA is held 3 cycles, o_hwdata/o_haddr stay stable, and o_done[1] appears 5 cycles after the request.
- Req0 at address 0x1002 → no o_hsel pulse, and o_done[0]=o_err[0]=1 two cycles after the request.
- Slave returns i_hresp=1 → o_err is coincident with o_done for the granted requester.
- Reset asserted during DATA → all outputs return to their reset values the same cycle with no done. After release, a pending req0 is served normally.
